// File: rtl/prover_compute_h_pkg.sv
// Shared field definitions for the prover: Mersenne-61 prime field, FSM states
// and combinational field add/multiply helpers.
package prover_compute_h_pkg;

    localparam int unsigned F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};  // 2^61 - 1

    typedef logic [F_NBITS-1:0] fe_t;

    typedef enum logic [2:0] {
        StIdle,
        StRestart,
        StUpdHi,
        StUpdLo,
        StDot0,
        StDot1,
        StDotWait
    } state_e;

    // (a + b) mod F_Q for reduced operands.
    function automatic fe_t f_add(input fe_t a, input fe_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) begin
            s = s - {1'b0, F_Q};
        end
        return s[F_NBITS-1:0];
    endfunction

    // (a * b) mod F_Q; folds the high half onto the low half since 2^61 == 1.
    function automatic fe_t f_mul(input fe_t a, input fe_t b);
        logic [2*F_NBITS-1:0] p;
        logic [F_NBITS:0]     s;
        p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        s = {1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]};
        s = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
        if (s >= {1'b0, F_Q}) begin
            s = s - {1'b0, F_Q};
        end
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/prover_adder_tree_pl.sv
// Pipelined modular adder tree: one register level per tree level, accepts a
// new input vector every cycle and carries a tag alongside the data.
module prover_adder_tree_pl
    import prover_compute_h_pkg::*;
#(
    parameter int unsigned ngates = 16,  // power of two, >= 2
    parameter int unsigned ntagb  = 1
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          in_valid,
    input  logic [ntagb-1:0]              in_tag,
    input  logic [ngates-1:0][F_NBITS-1:0] in_data,
    output logic                          out_valid,
    output logic [ntagb-1:0]              out_tag,
    output logic [F_NBITS-1:0]            out_data
);

    localparam int unsigned Depth = $clog2(ngates);

    // Heap-ordered nodes: leaves at [2*ngates-1:ngates], registered sums at
    // [ngates-1:1], root at 1.
    logic [2*ngates-1:1][F_NBITS-1:0] node;
    logic [ngates-1:1][F_NBITS-1:0]   sum_q, sum_d;
    logic [Depth-1:0]                 vld_q, vld_d;
    logic [Depth-1:0][ntagb-1:0]      tag_q, tag_d;

    assign node[2*ngates-1:ngates] = in_data;
    assign node[ngates-1:1]        = sum_q;

    // Each internal node sums its two children; valid/tag ride a matching shift chain.
    always_comb begin
        sum_d = '0;
        for (int unsigned n = 1; n < ngates; n++) begin
            sum_d[n] = f_add(node[2*n], node[2*n+1]);
        end
        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = in_valid;
        tag_d[0] = in_tag;
        for (int unsigned i = 1; i < Depth; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    // Pipeline registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            sum_q <= '0;
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            sum_q <= sum_d;
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign out_valid = vld_q[Depth-1];
    assign out_tag   = tag_q[Depth-1];
    assign out_data  = node[1];

endmodule

// File: rtl/prover_compute_h.sv
// Chi-vector builder and dot-product engine for the sum-check prover. NG shared
// field multipliers serve both the chi tensor expansion and the final dot product.
module prover_compute_h
    import prover_compute_h_pkg::*;
#(
    parameter int unsigned npoints = 5
) (
    input  logic                                  clk,
    input  logic                                  rstb,
    input  logic                                  en,
    input  logic                                  restart,
    input  logic [F_NBITS-1:0]                    tau,
    input  logic [F_NBITS-1:0]                    m_tau_p1,
    input  logic [(1<<npoints)-1:0][F_NBITS-1:0]  mvals_in,
    output logic                                  ready,
    output logic                                  ready_pulse,
    output logic [(1<<npoints)-1:0][F_NBITS-1:0]  chi_out,
    output logic [F_NBITS-1:0]                    h_out,
    output logic                                  h_ready_pulse
);

    localparam int unsigned NOUT = 1 << npoints;
    localparam int unsigned NG   = NOUT / 2;
    localparam int unsigned NgW  = $clog2(NG);
    localparam int unsigned RW   = $clog2(npoints + 2);
    localparam logic [RW-1:0] RLast = RW'(npoints);

    state_e                        state_q, state_d;
    logic [RW-1:0]                 r_q, r_d;
    logic [NOUT-1:0][F_NBITS-1:0]  chi_q, chi_d;
    logic [F_NBITS-1:0]            tau_q, tau_d, mtau_q, mtau_d;
    logic [F_NBITS-1:0]            acc_q, acc_d, h_q, h_d;
    logic                          ready_q, ready_d, rpulse_q, rpulse_d, hpulse_q, hpulse_d;

    logic [NG-1:0][F_NBITS-1:0]    mul_a, mul_b, prod;
    logic                          tree_in_vld, tree_out_vld;
    logic [0:0]                    tree_in_tag, tree_out_tag;
    logic [F_NBITS-1:0]            tree_sum;
    int unsigned                   pow;

    // Multiplier operand select: upper chi half uses tau, lower uses 1-tau,
    // dot passes pair chi with mvals for the low then high index range.
    always_comb begin
        mul_a       = '0;
        mul_b       = '0;
        prod        = '0;
        tree_in_vld = (state_q == StDot0) || (state_q == StDot1);
        tree_in_tag = (state_q == StDot1);
        for (int unsigned j = 0; j < NG; j++) begin
            case (state_q)
                StUpdHi: begin mul_a[j] = chi_q[j];      mul_b[j] = tau_q;            end
                StUpdLo: begin mul_a[j] = chi_q[j];      mul_b[j] = mtau_q;           end
                StDot0:  begin mul_a[j] = chi_q[j];      mul_b[j] = mvals_in[j];      end
                StDot1:  begin mul_a[j] = chi_q[NG+j];   mul_b[j] = mvals_in[NG+j];   end
                default: begin mul_a[j] = '0;            mul_b[j] = '0;               end
            endcase
            prod[j] = f_mul(mul_a[j], mul_b[j]);
        end
    end

    prover_adder_tree_pl #(
        .ngates (NG),
        .ntagb  (1)
    ) u_tree (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (tree_in_vld),
        .in_tag    (tree_in_tag),
        .in_data   (prod),
        .out_valid (tree_out_vld),
        .out_tag   (tree_out_tag),
        .out_data  (tree_sum)
    );

    // Round sequencing, chi writes and accumulation of the two tagged tree results.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        chi_d    = chi_q;
        tau_d    = tau_q;
        mtau_d   = mtau_q;
        acc_d    = acc_q;
        h_d      = h_q;
        ready_d  = ready_q;
        hpulse_d = 1'b0;
        pow      = 1 << r_q;

        case (state_q)
            StIdle: begin
                if (en && ready_q) begin
                    tau_d   = tau;
                    mtau_d  = m_tau_p1;
                    ready_d = 1'b0;
                    // r == 0 only after reset; out-of-range r restarts the sequence.
                    if (restart || (r_q == '0) || (r_q > RLast)) begin
                        state_d = StRestart;
                    end else if (r_q == RLast) begin
                        state_d = StDot0;
                    end else begin
                        state_d = StUpdHi;
                    end
                end
            end
            StRestart: begin
                chi_d    = '0;
                chi_d[0] = mtau_q;
                chi_d[1] = tau_q;
                r_d      = RW'(1);
                ready_d  = 1'b1;
                state_d  = StIdle;
            end
            StUpdHi: begin
                // Upper half first so the lower entries are still the old values.
                for (int unsigned k = 0; k < NOUT; k++) begin
                    if ((k >= pow) && (k < 2 * pow)) begin
                        chi_d[k] = prod[NgW'(k - pow)];
                    end
                end
                state_d = StUpdLo;
            end
            StUpdLo: begin
                for (int unsigned k = 0; k < NG; k++) begin
                    if (k < pow) begin
                        chi_d[k] = prod[k];
                    end
                end
                r_d     = r_q + RW'(1);
                ready_d = 1'b1;
                state_d = StIdle;
            end
            StDot0:    state_d = StDot1;
            StDot1:    state_d = StDotWait;
            StDotWait: state_d = StDotWait;
            default:   state_d = StIdle;
        endcase

        if (tree_out_vld) begin
            if (tree_out_tag == 1'b0) begin
                acc_d = tree_sum;
            end else begin
                h_d      = f_add(acc_q, tree_sum);
                hpulse_d = 1'b1;
                ready_d  = 1'b1;
                state_d  = StIdle;
            end
        end

        rpulse_d = ready_d & ~ready_q;
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q  <= StIdle;
            r_q      <= '0;
            chi_q    <= '0;
            tau_q    <= '0;
            mtau_q   <= '0;
            acc_q    <= '0;
            h_q      <= '0;
            ready_q  <= 1'b1;
            rpulse_q <= 1'b0;
            hpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            chi_q    <= chi_d;
            tau_q    <= tau_d;
            mtau_q   <= mtau_d;
            acc_q    <= acc_d;
            h_q      <= h_d;
            ready_q  <= ready_d;
            rpulse_q <= rpulse_d;
            hpulse_q <= hpulse_d;
        end
    end

    assign ready         = ready_q;
    assign ready_pulse   = rpulse_q;
    assign chi_out       = chi_q;
    assign h_out         = h_q;
    assign h_ready_pulse = hpulse_q;

endmodule

// File: tb/tb_prover_compute_h.sv
// Self-checking bench for prover_compute_h against a plain-arithmetic chi/h model.
module tb_prover_compute_h;

    localparam int NP   = 5;
    localparam int NOUT = 1 << NP;
    localparam logic [63:0] Q = 64'h1FFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic en = 1'b0;
    logic restart = 1'b0;
    logic [60:0] tau = '0;
    logic [60:0] m_tau_p1 = '0;
    logic [NOUT-1:0][60:0] mvals_in = '0;
    logic ready, ready_pulse, h_ready_pulse;
    logic [NOUT-1:0][60:0] chi_out;
    logic [60:0] h_out;

    int tests = 0;
    int fails = 0;

    logic [63:0] chi_m [NOUT];
    int          r_m;
    logic [63:0] h_m;

    prover_compute_h #(
        .npoints (NP)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .en            (en),
        .restart       (restart),
        .tau           (tau),
        .m_tau_p1      (m_tau_p1),
        .mvals_in      (mvals_in),
        .ready         (ready),
        .ready_pulse   (ready_pulse),
        .chi_out       (chi_out),
        .h_out         (h_out),
        .h_ready_pulse (h_ready_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] am(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] s;
        s = a + b;
        if (s >= Q) s = s - Q;
        return s;
    endfunction

    // Double-and-add modular multiply.
    function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] res;
        res = 0;
        for (int i = 60; i >= 0; i--) begin
            res = am(res, res);
            if (b[i]) res = am(res, a);
        end
        return res;
    endfunction

    function automatic logic [63:0] one_minus(input logic [63:0] t);
        return (t <= 1) ? (64'd1 - t) : (Q + 64'd1 - t);
    endfunction

    function automatic logic [63:0] rand_fe();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v % Q;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NOUT; i++) chi_m[i] = 0;
        r_m = 0;
        h_m = 0;
    endtask

    task automatic model_round(input logic rs, input logic [63:0] t, input logic [63:0] mt);
        if (rs || r_m == 0 || r_m > NP) begin
            for (int i = 0; i < NOUT; i++) chi_m[i] = 0;
            chi_m[0] = mt;
            chi_m[1] = t;
            r_m = 1;
        end else if (r_m < NP) begin
            for (int i = 0; i < (1 << r_m); i++) begin
                chi_m[i + (1 << r_m)] = mm(chi_m[i], t);
                chi_m[i] = mm(chi_m[i], mt);
            end
            r_m++;
        end else begin
            h_m = 0;
            for (int i = 0; i < NOUT; i++) h_m = am(h_m, mm({3'b0, mvals_in[i]}, chi_m[i]));
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < NOUT; i++)
            check($sformatf("%s chi[%0d]", tag, i), {3'b0, chi_out[i]}, chi_m[i]);
        check({tag, " h_out"}, {3'b0, h_out}, h_m);
    endtask

    // One round; with spam=1, en stays high with junk operands while busy.
    task automatic run_round(input logic rs, input logic [63:0] t, input logic spam,
                             input string tag);
        int cyc, rp, hp, lim;
        logic dot;
        logic [63:0] mt;
        mt  = one_minus(t);
        dot = !(rs || r_m == 0 || r_m > NP) && (r_m == NP);
        lim = dot ? NP + 6 : 4;
        cyc = 0;
        while (!ready && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, " ready_before_en"}, {63'b0, ready}, 64'd1);
        en = 1'b1; restart = rs; tau = t[60:0]; m_tau_p1 = mt[60:0];
        @(negedge clk);
        model_round(rs, t, mt);
        check({tag, " busy_after_en"}, {63'b0, ready}, 64'd0);
        if (spam) begin
            tau = 61'(rand_fe()); m_tau_p1 = 61'(rand_fe()); restart = 1'b1;
        end else begin
            en = 1'b0;
        end
        cyc = 1; rp = 0; hp = 0;
        while (!ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ready_pulse) rp++;
            if (h_ready_pulse) hp++;
        end
        en = 1'b0; restart = 1'b0;
        check({tag, " done_in_bound"}, {63'b0, (ready === 1'b1) && (cyc <= lim)}, 64'd1);
        check({tag, " ready_pulses"}, 64'(rp), 64'd1);
        check({tag, " h_pulses"}, 64'(hp), dot ? 64'd1 : 64'd0);
        check_state(tag);
    endtask

    task automatic run_sequence(input logic [63:0] t0, input logic fixed, input logic spam,
                                input string tag);
        run_round(1'b1, t0, 1'b0, {tag, " restart"});
        for (int k = 1; k < NP; k++)
            run_round(1'b0, fixed ? t0 : rand_fe(), (k == 2) && spam, $sformatf("%s upd%0d", tag, k));
        run_round(1'b0, rand_fe(), spam, {tag, " dot"});
    endtask

    initial begin
        int hp;
        model_reset();
        #1 rstb = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ready", {63'b0, ready}, 64'd1);
        check("reset ready_pulse", {63'b0, ready_pulse}, 64'd0);
        check("reset h_ready_pulse", {63'b0, h_ready_pulse}, 64'd0);
        check_state("reset");
        rstb = 1'b0;
        @(negedge clk);

        // tau = 0 everywhere: chi collapses onto index 0.
        for (int i = 0; i < NOUT; i++) mvals_in[i] = 61'(rand_fe());
        mvals_in[0] = 61'd7;
        run_sequence(64'd0, 1'b1, 1'b0, "tau0");
        check("tau0 chi0_is_1", {3'b0, chi_out[0]}, 64'd1);
        check("tau0 h_is_7", {3'b0, h_out}, 64'd7);

        // tau = 1 everywhere: chi collapses onto the last index.
        for (int i = 0; i < NOUT; i++) mvals_in[i] = 61'(i);
        run_sequence(64'd1, 1'b1, 1'b0, "tau1");
        check("tau1 chi31_is_1", {3'b0, chi_out[NOUT-1]}, 64'd1);
        check("tau1 h_is_31", {3'b0, h_out}, 64'd31);

        // tau = 2 with 1-tau = Q-1: sum of chi is 1.
        for (int i = 0; i < NOUT; i++) mvals_in[i] = 61'd1;
        run_sequence(64'd2, 1'b1, 1'b0, "tau2");
        check("tau2 h_is_1", {3'b0, h_out}, 64'd1);

        // en held while busy must be ignored.
        for (int i = 0; i < NOUT; i++) mvals_in[i] = 61'(rand_fe());
        run_sequence(rand_fe(), 1'b0, 1'b1, "spam");

        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < NOUT; i++) mvals_in[i] = 61'(rand_fe());
            run_sequence(rand_fe(), 1'b0, 1'b0, $sformatf("rand%0d", s));
        end

        // Reset in the middle of a dot round.
        for (int i = 0; i < NOUT; i++) mvals_in[i] = 61'(rand_fe());
        run_round(1'b1, rand_fe(), 1'b0, "rst_pre restart");
        for (int k = 1; k < NP; k++) run_round(1'b0, rand_fe(), 1'b0, "rst_pre upd");
        en = 1'b1; restart = 1'b0;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst ready", {63'b0, ready}, 64'd1);
        check("midrst h_ready_pulse", {63'b0, h_ready_pulse}, 64'd0);
        check_state("midrst");
        rstb = 1'b0;
        hp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (h_ready_pulse) hp++;
        end
        check("midrst no_h_pulse", 64'(hp), 64'd0);
        check_state("midrst held");
        // First en after reset with restart=0 still starts a new sequence.
        run_round(1'b0, rand_fe(), 1'b0, "post restart0");
        for (int k = 1; k < NP; k++) run_round(1'b0, rand_fe(), 1'b0, "post upd");
        run_round(1'b0, rand_fe(), 1'b0, "post dot");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prover_compute_h.md
PROVER_COMPUTE_H -- requirements
Module: prover_compute_h

Interface
REQ-001 SHALL have parameter npoints, default 5: number of tau rounds; NOUT = 2^npoints; NG = NOUT/2.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rstb  in  1  reset; one clock, asynchronous, active-high.
REQ-004 SHALL have port en  in  1  start one round; honoured only while ready=1.
REQ-005 SHALL have port restart  in  1  sampled with en; 1 = begin a new chi sequence.
REQ-006 SHALL have port tau  in  F_NBITS  round challenge, already reduced mod F_Q.
REQ-007 SHALL have port m_tau_p1  in  F_NBITS  (1 - tau) mod F_Q, supplied by the caller.
REQ-008 SHALL have port mvals_in  in  NOUT x F_NBITS  evaluation values, stable from the dot-product en until h_ready_pulse.
REQ-009 SHALL have port ready  out  1  idle; accepts en.
REQ-010 SHALL have port ready_pulse  out  1  one-cycle pulse on each 0->1 edge of ready.
REQ-011 SHALL have port chi_out  out  NOUT x F_NBITS  current chi vector (registered).
REQ-012 SHALL have port h_out  out  F_NBITS  dot product sum(mvals_in[i]*chi[i]) mod F_Q.
REQ-013 SHALL have port h_ready_pulse  out  1  one-cycle pulse when h_out updates.

Function
REQ-014 SHALL do all arithmetic mod F_Q; every output SHALL be < F_Q.
REQ-015 SHALL, on en with restart=1, set chi[0]=m_tau_p1, chi[1]=tau, other entries 0, and set round counter r=1.
REQ-016 SHALL, on en with restart=0 and 1<=r<npoints, for every i<2^r, set chi[i+2^r]=chi_old[i]*tau and chi[i]=chi_old[i]*m_tau_p1, then increment r.
REQ-017 SHALL, on en with restart=0 and r=npoints, ignore tau, leave chi unchanged, and compute h_out.
REQ-018 SHALL compute h with NG field multipliers, shared by chi update and dot product, in two passes: pass 0 over indices 0..NG-1 (tag 0), pass 1 over NG..NOUT-1 (tag 1).
REQ-019 SHALL feed each pass into a pipelined adder tree (sub-module) of depth npoints-1 that carries a 1-bit tag and accepts a new input every cycle.
REQ-020 SHALL accumulate tree outputs as follows: tag 0 loads the accumulator; tag 1 adds to it, updates h_out and pulses h_ready_pulse.
REQ-021 SHALL hold ready=0 from the cycle after an accepted en until chi is written (update rounds) or until h_ready_pulse (dot round).
REQ-022 SHALL complete an update round within 4 cycles of en and a dot round within npoints+6 cycles of en.
REQ-023 SHALL ignore en while ready=0, including en arriving in the same cycle that ready rises.
REQ-024 SHALL, on en with restart=0 and r>npoints, behave as restart=1; restart always overrides r.
REQ-025 SHALL hold h_out between dot rounds; a new sequence does not clear h_out.

Reset
REQ-026 SHALL, while rstb=1, asynchronously clear chi_out, h_out, accumulator, adder-tree pipeline, tags and r to 0, set ready=1, and hold ready_pulse and h_ready_pulse at 0.
REQ-027 SHALL abort any round in flight on reset mid-operation; the first en after reset SHALL require restart=1, otherwise REQ-024 applies.

Structure
REQ-028 SHALL take F_NBITS, F_Q and combinational field add/multiply functions from the shared field package (defaults F_Q=2^61-1, F_NBITS=61).
REQ-029 SHALL implement the pipelined tagged adder tree as sub-module prover_adder_tree_pl (parameter ngates, ntagb); the chi control and accumulator SHALL be internal to prover_compute_h.

Verification
REQ-030 SHALL pass: restart with tau=0, then 4 rounds with tau=0, dot round with mvals_in[0]=7 -> chi=[1,0,...,0], h_out=7.
REQ-031 SHALL pass: 5 rounds with tau=1 and mvals_in[i]=i -> chi[31]=1 and all others 0; h_out=31.
REQ-032 SHALL pass: 8 sequences of random tau and mvals_in -> chi_out and h_out match the software model (REQ-015..017) exactly.
REQ-033 SHALL pass: en pulsed while ready=0 -> ignored; r and chi unchanged.
REQ-034 SHALL pass: rstb asserted during the dot round -> all outputs 0, ready=1, no h_ready_pulse; a following restart sequence gives correct results.
REQ-035 SHALL pass: tau=2, m_tau_p1=F_Q-1 for all 5 rounds, mvals_in all 1 -> h_out=1, since sum of chi = (tau+1-tau)^5.
